// File: rtl/float_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: input capture, unpack/align, add/sub, normalise/round/pack.
// Define FLOAT_ADDSUB_RNE_EN for round-to-nearest-even; otherwise truncation with saturating overflow.
module float_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 nan,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 zero
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 4;                       // hidden + mantissa + G/R/S
    localparam int XW   = EXP_W + $clog2(MAN_W + 4) + 2;   // two's-complement working exponent
    localparam int EMAX = (1 << EXP_W) - 1;
`ifdef FLOAT_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    // Valid/ready: a transfer occurs on any edge where valid & ready are both high; every stage
    // advances together when the output slot is empty or being drained, otherwise all stages hold.
    logic adv;
    logic out_valid_q;
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;

    logic             p0_v_q, p0_op_q;
    logic [W-1:0]     p0_a_q, p0_b_q;

    logic             sa, sb, a_max, b_max, a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    assign sa    = p0_a_q[W-1];
    assign sb    = p0_b_q[W-1] ^ p0_op_q;
    assign ea    = p0_a_q[W-2:MAN_W];
    assign eb    = p0_b_q[W-2:MAN_W];
    assign ma    = (ea == '0) ? '0 : p0_a_q[MAN_W-1:0];
    assign mb    = (eb == '0) ? '0 : p0_b_q[MAN_W-1:0];
    assign a_max = &ea;
    assign b_max = &eb;
    assign a_nan = a_max && (|ma);
    assign b_nan = b_max && (|mb);
    assign a_inf = a_max && !(|ma);
    assign b_inf = b_max && !(|mb);

    logic             swap, s1_sign_d;
    logic [EXP_W-1:0] s1_exp_d, s_exp, diff;
    logic [MAN_W-1:0] l_man, s_man;
    logic [SW-1:0]    s1_sig_l_d, sig_s, s1_sig_s_d;
    logic [2*SW-1:0]  wide;
    int               shamt;

    always_comb begin
        swap       = {eb, mb} > {ea, ma};
        s1_sign_d  = swap ? sb : sa;
        s1_exp_d   = swap ? eb : ea;
        s_exp      = swap ? ea : eb;
        l_man      = swap ? mb : ma;
        s_man      = swap ? ma : mb;
        s1_sig_l_d = (s1_exp_d == '0) ? '0 : {1'b1, l_man, 3'b000};
        sig_s      = (s_exp == '0) ? '0 : {1'b1, s_man, 3'b000};
        diff       = s1_exp_d - s_exp;
        // Clamping at SW keeps every shifted-out bit inside the sticky window.
        shamt      = (int'(diff) > SW) ? SW : int'(diff);
        wide       = {sig_s, {SW{1'b0}}} >> shamt;
        s1_sig_s_d = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};
    end

    logic             s1_v_q, s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_sign_q, s1_sub_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_sig_l_q, s1_sig_s_q;

    logic [SW:0]      s2_sum_d;
    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_sig_l_q} - {1'b0, s1_sig_s_q})
                               : ({1'b0, s1_sig_l_q} + {1'b0, s1_sig_s_q});

    logic             s2_v_q, s2_nan_q, s2_inf_q, s2_inf_sign_q, s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0]      s2_sum_q;

    int               lz;
    logic [SW-1:0]    norm;
    logic [XW-1:0]    exp_n, exp_r;
    logic             rup;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] man_out;
    logic [W-1:0]     res_d;
    logic             nan_d, ovf_d, unf_d, zero_d;

    always_comb begin
        lz = SW;
        for (int i = 0; i < SW; i++) begin
            if (s2_sum_q[i]) lz = SW - 1 - i;
        end
        if (s2_sum_q[SW]) begin
            norm  = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = {{(XW-EXP_W){1'b0}}, s2_exp_q} + XW'(1);
        end else begin
            norm  = s2_sum_q[SW-1:0] << lz;
            exp_n = {{(XW-EXP_W){1'b0}}, s2_exp_q} - XW'(lz);
        end
        rup     = RNE && norm[2] && (norm[1] || norm[0] || norm[3]);
        mant_r  = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        exp_r   = exp_n + {{(XW-1){1'b0}}, mant_r[MAN_W+1]};
        man_out = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];

        res_d  = '0;
        nan_d  = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        if (s2_nan_q) begin
            res_d[W-2:MAN_W] = '1;
            res_d[MAN_W-1]   = 1'b1;
            nan_d            = 1'b1;
        end else if (s2_inf_q) begin
            res_d[W-1]       = s2_inf_sign_q;
            res_d[W-2:MAN_W] = '1;
        end else if (s2_sum_q == '0) begin
            zero_d = 1'b1;
        end else if (!exp_r[XW-1] && (exp_r >= XW'(EMAX))) begin
            res_d[W-1] = s2_sign_q;
            ovf_d      = 1'b1;
            if (RNE) begin
                res_d[W-2:MAN_W] = '1;
            end else begin
                res_d[W-2:MAN_W] = EXP_W'(EMAX - 1);
                res_d[MAN_W-1:0] = '1;
            end
        end else if (exp_r[XW-1] || (exp_r == '0)) begin
            res_d[W-1] = s2_sign_q;
            unf_d      = 1'b1;
            zero_d     = 1'b1;
        end else begin
            res_d = {s2_sign_q, exp_r[EXP_W-1:0], man_out};
        end
    end

    logic [W-1:0] result_q;
    logic         nan_q, ovf_q, unf_q, zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_v_q        <= 1'b0;
            p0_op_q       <= 1'b0;
            p0_a_q        <= '0;
            p0_b_q        <= '0;
            s1_v_q        <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            s1_inf_sign_q <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_exp_q      <= '0;
            s1_sig_l_q    <= '0;
            s1_sig_s_q    <= '0;
            s2_v_q        <= 1'b0;
            s2_nan_q      <= 1'b0;
            s2_inf_q      <= 1'b0;
            s2_inf_sign_q <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_sum_q      <= '0;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            nan_q         <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            zero_q        <= 1'b0;
        end else if (adv) begin
            p0_v_q        <= in_valid;
            p0_op_q       <= op;
            p0_a_q        <= a;
            p0_b_q        <= b;
            s1_v_q        <= p0_v_q;
            s1_nan_q      <= a_nan || b_nan || (a_inf && b_inf && (sa ^ sb));
            s1_inf_q      <= a_inf || b_inf;
            s1_inf_sign_q <= a_inf ? sa : sb;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= sa ^ sb;
            s1_exp_q      <= s1_exp_d;
            s1_sig_l_q    <= s1_sig_l_d;
            s1_sig_s_q    <= s1_sig_s_d;
            s2_v_q        <= s1_v_q;
            s2_nan_q      <= s1_nan_q;
            s2_inf_q      <= s1_inf_q;
            s2_inf_sign_q <= s1_inf_sign_q;
            s2_sign_q     <= s1_sign_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= s2_sum_d;
            out_valid_q   <= s2_v_q;
            result_q      <= res_d;
            nan_q         <= nan_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            zero_q        <= zero_d;
        end
    end

    assign result    = result_q;
    assign nan       = nan_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Bench for float_addsub_pipe: exact-arithmetic reference model, directed cases, random traffic.
module tb_float_addsub_pipe;
    localparam int E    = 8;
    localparam int M    = 23;
    localparam int W    = 1 + E + M;
    localparam int BIG  = 320;
    localparam int EMAX = (1 << E) - 1;
`ifdef FLOAT_ADDSUB_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, op, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic         nan, overflow, underflow, zero;

    always #5 clk = ~clk;

    float_addsub_pipe #(.EXP_W(E), .MAN_W(M)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero)
    );

    int             checks = 0;
    int             errors = 0;
    logic [W+3:0]   exp_q[$];
    logic           seen_valid;
    logic [W+3:0]   last_got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Exact value in units of the smallest normal ulp, then rounded from the exact magnitude.
    function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        logic sx, sy, s, x_nan, y_nan, x_inf, y_inf;
        int ex, ey, p, e, sh;
        logic [M-1:0] mx, my;
        bit [BIG-1:0] vx, vy, mag, rem, half, one, t;
        longint unsigned mant;
        logic [W-1:0] r;
        logic [3:0] f;
        one = 1;
        sx = x[W-1];
        sy = y[W-1] ^ o;
        ex = int'(x[W-2:M]);
        ey = int'(y[W-2:M]);
        mx = x[M-1:0];
        my = y[M-1:0];
        x_nan = (ex == EMAX) && (mx != 0);
        y_nan = (ey == EMAX) && (my != 0);
        x_inf = (ex == EMAX) && (mx == 0);
        y_inf = (ey == EMAX) && (my == 0);
        r = '0;
        f = 4'b0000;
        if (x_nan || y_nan || (x_inf && y_inf && sx != sy)) begin
            r[W-2:M] = '1;
            r[M-1] = 1'b1;
            f = 4'b1000;
        end else if (x_inf || y_inf) begin
            r[W-1] = x_inf ? sx : sy;
            r[W-2:M] = '1;
        end else begin
            vx = (ex == 0) ? '0 : (BIG'({1'b1, mx}) << (ex - 1));
            vy = (ey == 0) ? '0 : (BIG'({1'b1, my}) << (ey - 1));
            if (sx == sy) begin mag = vx + vy; s = sx; end
            else if (vx >= vy) begin mag = vx - vy; s = sx; end
            else begin mag = vy - vx; s = sy; end
            if (mag == 0) begin
                f = 4'b0001;
            end else begin
                p = 0;
                for (int i = 0; i < BIG; i++) if (mag[i]) p = i;
                if (p < M) begin
                    r[W-1] = s;
                    f = 4'b0011;
                end else begin
                    sh = p - M;
                    e = p - M + 1;
                    t = mag >> sh;
                    mant = t[63:0];
                    rem = mag & ((one << sh) - one);
                    half = (sh > 0) ? (one << (sh - 1)) : '0;
                    if (RNE && sh > 0 && (rem > half || (rem == half && mant[0]))) mant++;
                    if (mant == (64'd1 << (M + 1))) begin mant = mant >> 1; e++; end
                    if (e >= EMAX) begin
                        r[W-1] = s;
                        f = 4'b0100;
                        if (RNE) r[W-2:M] = '1;
                        else begin r[W-2:M] = E'(EMAX - 1); r[M-1:0] = '1; end
                    end else begin
                        r = {s, e[E-1:0], mant[M-1:0]};
                    end
                end
            end
        end
        return {r, f};
    endfunction

    // One cycle: drive at negedge, then score outputs and record accepted inputs.
    task automatic step(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic top, input logic ordy, output logic acc);
        logic [W+3:0] got;
        @(negedge clk);
        in_valid = iv; a = ta; b = tbv; op = top; out_ready = ordy;
        #1;
        got = {result, nan, overflow, underflow, zero};
        seen_valid = out_valid;
        last_got = got;
        if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
            else if (out_ready) chk("result", 64'(got), 64'(exp_q.pop_front()));
            else chk("held_out", 64'(got), 64'(exp_q[0]));
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(model(ta, tbv, top));
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0) r[W-2:M] = '0;
        else if (k == 1) begin r[W-2:M] = '1; r[M-1:0] = '0; end
        else if (k == 2) begin r[W-2:M] = '1; r[0] = 1'b1; end
        else if (k == 3) r[W-2:M] = E'(EMAX - 1);
        else if (k == 4) r[W-2:M] = E'(1);
        else r[W-2:M] = E'($urandom_range(1, EMAX - 1));
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int first, sent, stalls, idle_valid;
        logic [W-1:0] ops[5];
        logic [W-1:0] xa, xb;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({nan, overflow, underflow, zero}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        chk("pin_add", 64'(model(32'h3F800000, 32'h40000000, 1'b0)), {28'd0, 32'h40400000, 4'b0000});
        chk("pin_cancel", 64'(model(32'h3F800000, 32'h3F800000, 1'b1)), {28'd0, 32'h00000000, 4'b0001});
        chk("pin_ovf", 64'(model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0)),
            {28'd0, (RNE ? 32'h7F800000 : 32'h7F7FFFFF), 4'b0100});
        chk("pin_inf_nan", 64'(model(32'h7F800000, 32'hFF800000, 1'b0)), {28'd0, 32'h7FC00000, 4'b1000});
        chk("pin_qnan", 64'(model(32'h7FC00001, 32'h3F800000, 1'b0)), {28'd0, 32'h7FC00000, 4'b1000});
        chk("pin_round", 64'(model(32'h3F800001, 32'h33800000, 1'b0)),
            {28'd0, (RNE ? 32'h3F800002 : 32'h3F800001), 4'b0000});
        chk("pin_unf", 64'(model(32'h00800000, 32'h00800001, 1'b1)), {28'd0, 32'h80000000, 4'b0011});

        step(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, acc);
        chk("latency_accept", 64'(acc), 64'd1);
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (seen_valid && first == 0) begin
                first = k;
                chk("latency_result", 64'(last_got), {28'd0, 32'h40400000, 4'b0000});
            end
        end
        chk("latency", 64'(first), 64'd4);

        step(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1, acc);
        step(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, acc);
        step(1'b1, 32'h7F800000, 32'hFF800000, 1'b0, 1'b1, acc);
        step(1'b1, 32'h7FC00001, 32'h3F800000, 1'b0, 1'b1, acc);
        step(1'b1, 32'h3F800001, 32'h33800000, 1'b0, 1'b1, acc);
        step(1'b1, 32'h00800000, 32'h00800001, 1'b1, 1'b1, acc);
        for (int k = 0; k < 8; k++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("directed_drain", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 5; i++) ops[i] = rnd_op();
        sent = 0; stalls = 0;
        for (int k = 0; k < 40 && (sent < 5 || exp_q.size() != 0); k++) begin
            step(sent < 5, ops[sent % 5], ops[(sent + 2) % 5], sent[0], stalls >= 4, acc);
            if (acc) sent++;
            if (seen_valid && stalls < 4) begin
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                stalls++;
            end
        end
        chk("bp_sent", 64'(sent), 64'd5);
        chk("bp_drain", 64'(exp_q.size()), 64'd0);

        step(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, 1'b0, acc);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_result", 64'(result), 64'd0);
        chk("async_reset_flags", 64'({nan, overflow, underflow, zero}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_valid = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (seen_valid) idle_valid++;
        end
        chk("post_reset_idle", 64'(idle_valid), 64'd0);

        for (int k = 0; k < 2000; k++) begin
            xa = rnd_op();
            if ($urandom_range(0, 9) < 3) xb = {xa[W-1:4], 4'($urandom_range(0, 15))};
            else xb = rnd_op();
            step($urandom_range(0, 9) < 8, xa, xb, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, acc);
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("random_drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_addsub_pipe.md
Name: float_addsub_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the single-format float_add.
- Exponent and mantissa widths are generic. Per-transaction add/sub select, valid/ready handshake with backpressure, fixed 3-stage latency.
- Status flags nan/overflow/underflow/zero travel with each result.
- Sits between operand sources and downstream float consumers in the arithmetic datapath.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored mantissa field width, hidden bit excluded (>=2).
- W, derived localparam = 1+EXP_W+MAN_W, total word width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline state.
- in_valid  in  1  operands a, b, op presented.
- in_ready  out  1  block accepts input this cycle.
- a  in  W  operand A {sign, exp, man}.
- b  in  W  operand B.
- op  in  1  0 = a+b, 1 = a-b (b sign inverted at stage 1).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts result.
- result  out  W  sum/difference.
- nan  out  1  result is canonical NaN.
- overflow  out  1  finite operands produced infinity.
- underflow  out  1  nonzero exact result flushed to zero.
- zero  out  1  result is +0 or -0.

Behaviour:
- Reset (async, any time, including mid-operation): all stage valid bits = 0, out_valid = 0, result = 0, all flags = 0. In-flight operations are discarded. The pipeline accepts input on the first clk edge after reset deasserts.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational.
  - All three stages shift together when adv = 1. A transfer happens on in_valid & in_ready.
  - When adv = 0 every stage holds: result and flags stable, no data lost.
  - Bubbles (stage valid = 0) shift through like data.
- Latency: an operand accepted at edge N appears with out_valid = 1 after edge N+3, provided adv stays 1. Throughput is one operation per cycle.
- Stage 1, unpack/align:
  - Classify operands: exp all-ones & man = 0 -> inf; exp all-ones & man != 0 -> NaN; exp = 0 -> zero (subnormal inputs are flushed to zero).
  - Apply op to the sign of b.
  - Swap so that |A| >= |B|, comparing exponent then mantissa.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round, and sticky bits. A shift >= MAN_W+3 leaves only sticky.
- Stage 2, add/sub:
  - Effective operation is add when signs are equal, else subtract, on (MAN_W+4)-bit significands plus a carry bit.
  - Result sign = sign of the larger operand.
- Stage 3, normalise/round/pack:
  - Carry out -> shift right by 1, exp+1.
  - Otherwise leading-zero count, then shift left and decrement exp.
  - Round according to the optional feature; a rounding carry renormalises.
- Special cases, in priority order:
  - Any NaN input, or inf + (-inf) effective -> result {0, all-ones, 1, 0...} (0x7FC00000 for 8/23), nan = 1.
  - Inf operand -> signed inf, no flags.
  - Exact cancellation -> +0, zero = 1.
  - Biased exp >= 2^EXP_W-1 after rounding -> signed inf, overflow = 1.
  - Biased exp <= 0 with nonzero magnitude -> signed zero, underflow = 1, zero = 1.
- Flags are mutually exclusive except that underflow implies zero.

Optional Feature:
- Macro FLOAT_ADDSUB_RNE_EN.
- Defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- Undefined: truncate (round toward zero). G/R/S are still computed but ignored, and overflow saturates to the largest finite value instead of inf, with overflow = 1.

Test Plan:
- Latency: a=0x3F800000, b=0x40000000, op=0, in_valid pulse at edge N, out_ready=1 -> out_valid at edge N+3, result 0x40400000, all flags 0.
- Cancel: a=0x3F800000, b=0x3F800000, op=1 -> result 0x00000000, zero=1.
- Overflow: a=b=0x7F7FFFFF, op=0 -> with RNE_EN result 0x7F800000, overflow=1; without it result 0x7F7FFFFF, overflow=1.
- NaN: a=0x7F800000, b=0xFF800000, op=0 -> 0x7FC00000, nan=1. a=0x7FC00001, b=0x3F800000 -> 0x7FC00000, nan=1.
- Rounding and underflow:
  - a=0x3F800001, b=0x33800000, op=0 -> RNE_EN: 0x3F800002; truncate: 0x3F800001.
  - a=0x00800000, b=0x00800001, op=1 -> 0x80000000, underflow=1, zero=1.
- Backpressure/reset:
  - Stream 5 back-to-back ops; hold out_ready=0 for 4 cycles once out_valid=1 -> in_ready=0 and result stable throughout; after release all 5 results arrive in order, none lost or duplicated.
  - Assert reset with 2 ops in flight -> out_valid=0 immediately, and no stale result appears after reset deasserts.
